// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 Scan Code Set 2 ASCII encoder:
// protocol constants, encoder state type, lookup result record and the
// unshifted ASCII -> make-code table.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SH_MAKE    = 3'd1,
    MAKE       = 3'd2,
    HOLD       = 3'd3,
    BRK_PFX    = 3'd4,
    BRK        = 3'd5,
    SH_BRK_PFX = 3'd6,
    SH_BRK     = 3'd7
  } ps2_enc_state_t;

  typedef struct packed {
    logic       supported;
    logic       shift;
    logic [7:0] code;
  } ps2_lut_t;

  // Make code for characters typed without shift; 00 means "no key".
  function automatic logic [7:0] ps2_base_code(input logic [7:0] ch);
    logic [7:0] c;
    case (ch)
      8'h61: c = 8'h1C; // a
      8'h62: c = 8'h32; // b
      8'h63: c = 8'h21; // c
      8'h64: c = 8'h23; // d
      8'h65: c = 8'h24; // e
      8'h66: c = 8'h2B; // f
      8'h67: c = 8'h34; // g
      8'h68: c = 8'h33; // h
      8'h69: c = 8'h43; // i
      8'h6A: c = 8'h3B; // j
      8'h6B: c = 8'h42; // k
      8'h6C: c = 8'h4B; // l
      8'h6D: c = 8'h3A; // m
      8'h6E: c = 8'h31; // n
      8'h6F: c = 8'h44; // o
      8'h70: c = 8'h4D; // p
      8'h71: c = 8'h15; // q
      8'h72: c = 8'h2D; // r
      8'h73: c = 8'h1B; // s
      8'h74: c = 8'h2C; // t
      8'h75: c = 8'h3C; // u
      8'h76: c = 8'h2A; // v
      8'h77: c = 8'h1D; // w
      8'h78: c = 8'h22; // x
      8'h79: c = 8'h35; // y
      8'h7A: c = 8'h1A; // z
      8'h30: c = 8'h45; // 0
      8'h31: c = 8'h16; // 1
      8'h32: c = 8'h1E; // 2
      8'h33: c = 8'h26; // 3
      8'h34: c = 8'h25; // 4
      8'h35: c = 8'h2E; // 5
      8'h36: c = 8'h36; // 6
      8'h37: c = 8'h3D; // 7
      8'h38: c = 8'h3E; // 8
      8'h39: c = 8'h46; // 9
      8'h20: c = 8'h29; // space
      8'h0D: c = 8'h5A; // Enter
      8'h08: c = 8'h66; // Backspace
      8'h09: c = 8'h0D; // Tab
      8'h2D: c = 8'h4E; // -
      8'h3D: c = 8'h55; // =
      8'h5C: c = 8'h5D; // backslash
      8'h5B: c = 8'h54; // [
      8'h5D: c = 8'h5B; // ]
      8'h3B: c = 8'h4C; // ;
      8'h27: c = 8'h52; // '
      8'h2C: c = 8'h41; // ,
      8'h2E: c = 8'h49; // .
      8'h2F: c = 8'h4A; // /
      8'h60: c = 8'h0E; // backtick
      default: c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ps2_ascii2scancode_lut.sv
// Combinational ASCII -> Scan Code Set 2 lookup.
// Optional feature macro: PS2_ASCII_SHIFT_EN adds the shifted characters
// (uppercase letters and shifted punctuation) with the shift flag set;
// without it those characters report supported = 0.
module ps2_ascii2scancode_lut
  import ps2_pkg::*;
(
  input  logic [7:0] ascii,
  output ps2_lut_t   result
);

  logic [7:0] base_code;

  assign base_code = ps2_base_code(ascii);

`ifdef PS2_ASCII_SHIFT_EN
  logic [7:0] shift_code;

  // Shifted characters reuse the make code of their unshifted key.
  function automatic logic [7:0] shifted_code(input logic [7:0] ch);
    logic [7:0] c;
    if (ch >= 8'h41 && ch <= 8'h5A) begin
      c = ps2_base_code(ch | 8'h20);
    end else begin
      case (ch)
        8'h21: c = 8'h16; // !
        8'h40: c = 8'h1E; // @
        8'h23: c = 8'h26; // #
        8'h24: c = 8'h25; // $
        8'h25: c = 8'h2E; // %
        8'h5E: c = 8'h36; // ^
        8'h26: c = 8'h3D; // &
        8'h2A: c = 8'h3E; // *
        8'h28: c = 8'h46; // (
        8'h29: c = 8'h45; // )
        8'h5F: c = 8'h4E; // _
        8'h2B: c = 8'h55; // +
        8'h7C: c = 8'h5D; // |
        8'h7B: c = 8'h54; // {
        8'h7D: c = 8'h5B; // }
        8'h3A: c = 8'h4C; // :
        8'h22: c = 8'h52; // "
        8'h3C: c = 8'h41; // <
        8'h3E: c = 8'h49; // >
        8'h3F: c = 8'h4A; // ?
        8'h7E: c = 8'h0E; // ~
        default: c = 8'h00;
      endcase
    end
    return c;
  endfunction

  assign shift_code = shifted_code(ascii);
`endif

  // Select the unshifted mapping first, then the shifted one if enabled.
  always_comb begin
    result = '0;
    if (base_code != 8'h00) begin
      result.supported = 1'b1;
      result.code      = base_code;
    end
`ifdef PS2_ASCII_SHIFT_EN
    else if (shift_code != 8'h00) begin
      result.supported = 1'b1;
      result.shift     = 1'b1;
      result.code      = shift_code;
    end
`endif
  end

endmodule

// File: rtl/ps2_ascii2scancode.sv
// ASCII character -> PS/2 Set 2 key-press byte stream (make, F0, make),
// optionally wrapped in left-shift make/break when PS2_ASCII_SHIFT_EN is
// defined. HOLD_CYCLES idle cycles separate the make transfer from the
// break prefix to emulate a key being held down.
module ps2_ascii2scancode
  import ps2_pkg::*;
#(
  parameter int HOLD_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ascii,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  input  logic       scan_ready,
  output logic       unsupported
);

  localparam int CNT_W       = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int HOLD_LAST_I = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_LAST_I);

  ps2_enc_state_t   state;
  ps2_lut_t         lut;
  logic [7:0]       code_q;
  logic [CNT_W-1:0] hold_cnt;
  logic             accept;

`ifdef PS2_ASCII_SHIFT_EN
  logic             shift_q;
`else
  logic             unused_shift;
  assign unused_shift = lut.shift;
`endif

  ps2_ascii2scancode_lut u_lut (
    .ascii  (ascii),
    .result (lut)
  );

  assign ascii_ready = (state == IDLE);
  assign accept      = ascii_valid && (state == IDLE);

  // Capture the looked-up make code (and shift flag) for the whole sequence.
  always_ff @(posedge clk) begin
    if (accept) begin
      code_q  <= lut.code;
`ifdef PS2_ASCII_SHIFT_EN
      shift_q <= lut.shift;
`endif
    end
  end

  // Sequencer: one state per emitted byte, advancing on each transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      scan_code   <= 8'h00;
      scan_valid  <= 1'b0;
      unsupported <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      unsupported <= 1'b0;
      case (state)
        IDLE: begin
          if (ascii_valid) begin
            if (!lut.supported) begin
              unsupported <= 1'b1;
            end
`ifdef PS2_ASCII_SHIFT_EN
            else if (lut.shift) begin
              state      <= SH_MAKE;
              scan_code  <= PS2_LSHIFT;
              scan_valid <= 1'b1;
            end
`endif
            else begin
              state      <= MAKE;
              scan_code  <= lut.code;
              scan_valid <= 1'b1;
            end
          end
        end
`ifdef PS2_ASCII_SHIFT_EN
        SH_MAKE: begin
          if (scan_ready) begin
            state     <= MAKE;
            scan_code <= code_q;
          end
        end
`endif
        MAKE: begin
          if (scan_ready) begin
            if (HOLD_CYCLES == 0) begin
              state     <= BRK_PFX;
              scan_code <= PS2_BREAK;
            end else begin
              state      <= HOLD;
              scan_valid <= 1'b0;
              hold_cnt   <= '0;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= BRK_PFX;
            scan_code  <= PS2_BREAK;
            scan_valid <= 1'b1;
            hold_cnt   <= '0;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        BRK_PFX: begin
          if (scan_ready) begin
            state     <= BRK;
            scan_code <= code_q;
          end
        end
        BRK: begin
          if (scan_ready) begin
`ifdef PS2_ASCII_SHIFT_EN
            if (shift_q) begin
              state     <= SH_BRK_PFX;
              scan_code <= PS2_BREAK;
            end else begin
              state      <= IDLE;
              scan_valid <= 1'b0;
            end
`else
            state      <= IDLE;
            scan_valid <= 1'b0;
`endif
          end
        end
`ifdef PS2_ASCII_SHIFT_EN
        SH_BRK_PFX: begin
          if (scan_ready) begin
            state     <= SH_BRK;
            scan_code <= PS2_LSHIFT;
          end
        end
        SH_BRK: begin
          if (scan_ready) begin
            state      <= IDLE;
            scan_valid <= 1'b0;
          end
        end
`endif
        default: begin
          state      <= IDLE;
          scan_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_ascii2scancode.sv
// Bench for ps2_ascii2scancode: table of characters with expected byte
// streams, plus sequences for backpressure, hold gap and mid-sequence reset.
// Honours PS2_ASCII_SHIFT_EN for the shifted-character expectations.
module tb_ps2_ascii2scancode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] ascii0, ascii3, code0, code3;
  logic       av0, av3, ar0, ar3, sv0, sv3, sr0, sr3, un0, un3;

  ps2_ascii2scancode #(.HOLD_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ascii(ascii0), .ascii_valid(av0), .ascii_ready(ar0),
    .scan_code(code0), .scan_valid(sv0), .scan_ready(sr0), .unsupported(un0)
  );

  ps2_ascii2scancode #(.HOLD_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ascii(ascii3), .ascii_valid(av3), .ascii_ready(ar3),
    .scan_code(code3), .scan_valid(sv3), .scan_ready(sr3), .unsupported(un3)
  );

  typedef struct {
    logic [7:0]  ascii;
    int          nbytes;
    logic [47:0] bytes;   // first byte in [47:40]
    int          unsup;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] q0[$];
  logic [7:0] q3[$];
  int         unsup0, unsup3;
  bit         stall0, stall3;
  logic [7:0] stall_code0, stall_code3;
  bit         bp_mode;
  int         bp_cnt;
  logic       rdy0_s, rdy3_s, v0_s, v3_s;
  vec_t       vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // kind: 0 = plain key, 1 = unsupported, 2 = shifted key
  function automatic vec_t mk(input logic [7:0] ch, input logic [7:0] c, input int kind);
    vec_t v;
    v.ascii = ch;
    v.unsup = 0;
    v.bytes = '0;
    if (kind == 1) begin
      v.nbytes = 0;
      v.unsup  = 1;
    end else if (kind == 2) begin
      v.nbytes = 6;
      v.bytes  = {8'h12, c, 8'hF0, c, 8'hF0, 8'h12};
    end else begin
      v.nbytes = 3;
      v.bytes  = {c, 8'hF0, c, 24'h0};
    end
    return v;
  endfunction

  task automatic monitor();
    if (rst_n && sv0 && sr0) begin
      if (q0.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut0 unexpected byte: got %0h, expected no byte", code0);
      end else begin
        check("dut0 byte", code0, q0.pop_front());
      end
    end
    if (stall0) check("dut0 stall stable", {sv0, code0}, {1'b1, stall_code0});
    stall0      = rst_n && sv0 && !sr0;
    stall_code0 = code0;
    if (un0) unsup0++;

    if (rst_n && sv3 && sr3) begin
      if (q3.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut3 unexpected byte: got %0h, expected no byte", code3);
      end else begin
        check("dut3 byte", code3, q3.pop_front());
      end
    end
    if (stall3) check("dut3 stall stable", {sv3, code3}, {1'b1, stall_code3});
    stall3      = rst_n && sv3 && !sr3;
    stall_code3 = code3;
    if (un3) unsup3++;

    rdy0_s = ar0; rdy3_s = ar3; v0_s = sv0; v3_s = sv3;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (bp_mode) begin
      sr0 = ((bp_cnt % 4) == 0) || ((bp_cnt % 4) == 3);
      bp_cnt++;
    end
  endtask

  task automatic send(input bit d3, input logic [7:0] ch, output bit ok);
    ok = 1'b0;
    if (d3) begin ascii3 = ch; av3 = 1'b1; end
    else    begin ascii0 = ch; av0 = 1'b1; end
    for (int i = 0; i < 50; i++) begin
      step();
      if (d3 ? rdy3_s : rdy0_s) begin
        ok = 1'b1;
        break;
      end
    end
    av0 = 1'b0;
    av3 = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    bit ok, idle;
    int busy;
    for (int i = 0; i < v.nbytes; i++) q0.push_back(v.bytes[47-8*i -: 8]);
    unsup0 = 0;
    send(1'b0, v.ascii, ok);
    check($sformatf("%s accepted", name), {31'b0, ok}, 32'd1);
    busy = 0;
    idle = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (rdy0_s) begin
        idle = 1'b1;
        break;
      end
      busy++;
    end
    check($sformatf("%s back to idle", name), {31'b0, idle}, 32'd1);
    if (!bp_mode) check($sformatf("%s busy cycles", name), busy, v.nbytes);
    check($sformatf("%s bytes left", name), q0.size(), 0);
    check($sformatf("%s unsupported pulses", name), unsup0, v.unsup);
  endtask

  initial begin
    bit ok;
    logic [9:0] trace_v, trace_r;

    vecs[0]  = mk(8'h61, 8'h1C, 0);
    vecs[1]  = mk(8'h7A, 8'h1A, 0);
    vecs[2]  = mk(8'h35, 8'h2E, 0);
    vecs[3]  = mk(8'h30, 8'h45, 0);
    vecs[4]  = mk(8'h20, 8'h29, 0);
    vecs[5]  = mk(8'h0D, 8'h5A, 0);
    vecs[6]  = mk(8'h08, 8'h66, 0);
    vecs[7]  = mk(8'h09, 8'h0D, 0);
    vecs[8]  = mk(8'h5C, 8'h5D, 0);
    vecs[9]  = mk(8'h60, 8'h0E, 0);
    vecs[10] = mk(8'h3B, 8'h4C, 0);
    vecs[11] = mk(8'h7F, 8'h00, 1);
`ifdef PS2_ASCII_SHIFT_EN
    vecs[12] = mk(8'h41, 8'h1C, 2);
    vecs[13] = mk(8'h7E, 8'h0E, 2);
    vecs[14] = mk(8'h21, 8'h16, 2);
    vecs[15] = mk(8'h3F, 8'h4A, 2);
`else
    vecs[12] = mk(8'h41, 8'h00, 1);
    vecs[13] = mk(8'h7E, 8'h00, 1);
    vecs[14] = mk(8'h21, 8'h00, 1);
    vecs[15] = mk(8'h3F, 8'h00, 1);
`endif

    rst_n = 1'b0;
    ascii0 = 8'h00; ascii3 = 8'h00;
    av0 = 1'b0; av3 = 1'b0;
    sr0 = 1'b1; sr3 = 1'b1;
    bp_mode = 1'b0; bp_cnt = 0;
    stall0 = 1'b0; stall3 = 1'b0;
    unsup0 = 0; unsup3 = 0;

    // Reset state
    step();
    step();
    rst_n = 1'b1;
    step();
    check("reset ascii_ready", {31'b0, ar0}, 32'd1);
    check("reset scan_valid", {31'b0, sv0}, 32'd0);
    check("reset scan_code", {24'b0, code0}, 32'h00);
    check("reset unsupported", {31'b0, un0}, 32'd0);
    check("reset dut3 ready/valid", {30'b0, ar3, sv3}, 32'd2);

    // Character table, scan_ready held high
    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: 'q' with scan_ready 1,0,0,1,...
    bp_mode = 1'b1;
    bp_cnt  = 0;
    run_vec(mk(8'h71, 8'h15, 0), "backpressure q");
    bp_mode = 1'b0;
    sr0 = 1'b1;
    step();

    // Hold gap on the HOLD_CYCLES=3 instance: 'z'
    q3.push_back(8'h1A); q3.push_back(8'hF0); q3.push_back(8'h1A);
    unsup3 = 0;
    send(1'b1, 8'h7A, ok);
    check("hold accepted", {31'b0, ok}, 32'd1);
    trace_v = '0;
    trace_r = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      trace_v[9-i] = v3_s;
      trace_r[9-i] = rdy3_s;
    end
    check("hold valid trace", {22'b0, trace_v}, {22'b0, 10'b1000110000});
    check("hold ready trace", {22'b0, trace_r}, {22'b0, 10'b0000001111});
    check("hold bytes left", q3.size(), 0);
    check("hold unsupported", unsup3, 0);

    // Reset after the make byte of 'a'
    q0.push_back(8'h1C);
    send(1'b0, 8'h61, ok);
    check("reset-seq accepted", {31'b0, ok}, 32'd1);
    step();
    rst_n = 1'b0;
    sr0   = 1'b0;
    step();
    step();
    check("reset-seq scan_valid", {31'b0, v0_s}, 32'd0);
    check("reset-seq ascii_ready", {31'b0, rdy0_s}, 32'd1);
    check("reset-seq bytes left", q0.size(), 0);
    rst_n = 1'b1;
    sr0   = 1'b1;
    step();
    run_vec(mk(8'h62, 8'h32, 0), "after reset b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
